// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and state encoding for the register file
//               write-port controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-request round-robin arbiter with one-hot grant; after any
//               grant the priority moves to the requester that lost.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Req,
    output logic [1:0] Grant
);

    // 0: requester 0 preferred, 1: requester 1 preferred
    logic r_prio;

    always_comb begin
        Grant = Req;
        if (Req == 2'b11) begin
            Grant = r_prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_prio <= 1'b0;
        end else if (|Grant) begin
            r_prio <= Grant[0];
        end
    end

endmodule : rr_arbiter2

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file write port between two writeback
//               requesters; optional post-reset clear via REGFILE_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int                DATA_W      = REG_DATA_W,
    parameter int                ADDR_W      = REG_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              AValid,
    input  logic [ADDR_W-1:0] AAddr,
    input  logic [DATA_W-1:0] AData,
    output logic              AReady,
    input  logic              BValid,
    input  logic [ADDR_W-1:0] BAddr,
    input  logic [DATA_W-1:0] BData,
    output logic              BReady,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              ClearDone
);

    localparam logic [0:0] ST_CLEAR = CLEAR;
    localparam logic [0:0] ST_RUN   = RUN;

    logic              w_clearing;
    logic [ADDR_W-1:0] w_clr_addr;

`ifdef REGFILE_CLEAR_EN
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (&r_clr_cnt) begin
                r_state <= ST_RUN;
            end
        end
    end

    assign w_clearing = (r_state == ST_CLEAR);
    assign w_clr_addr = r_clr_cnt;
    assign ClearDone  = (r_state == ST_RUN);
`else
    assign w_clearing = 1'b0;
    assign w_clr_addr = '0;
    assign ClearDone  = 1'b1;
`endif

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Masking with Reset keeps Ready low in the reset cycle in both builds.
    assign w_req = {BValid, AValid} & {2{~w_clearing & ~Reset}};

    rr_arbiter2 u_arb (
        .Clock (Clock),
        .Reset (Reset),
        .Req   (w_req),
        .Grant (w_grant)
    );

    assign AReady   = w_grant[0];
    assign BReady   = w_grant[1];
    assign w_accept = |w_grant;
    assign w_addr   = w_grant[1] ? BAddr : AAddr;
    assign w_data   = w_grant[1] ? BData : AData;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            RegWrite  <= 1'b1;
            WriteAddr <= '0;
            WriteData <= '0;
        end else if (w_clearing) begin
            RegWrite  <= 1'b0;
            WriteAddr <= w_clr_addr;
            WriteData <= CLEAR_VALUE;
        end else if (w_accept && (w_addr != ADDR_W'(ZERO_REG))) begin
            RegWrite  <= 1'b0;
            WriteAddr <= w_addr;
            WriteData <= w_data;
        end else begin
            // Idle or $zero drop: address/data hold their last values.
            RegWrite  <= 1'b1;
        end
    end

endmodule : regfile_wb_arbiter

`default_nettype wire
